// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port among debug, LSU and ALU.
// Fixed priority debug > LSU > ALU, with a starvation counter that force-grants a waiting ALU.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk_i,
    input  logic             reset,

    input  logic             dbg_valid_i,
    input  logic [4:0]       dbg_rd_i,
    input  logic [31:0]      dbg_data_i,
    output logic             dbg_ready_o,

    input  logic             lsu_valid_i,
    input  logic [4:0]       lsu_rd_i,
    input  logic [31:0]      lsu_data_i,
    output logic             lsu_ready_o,

    input  logic             alu_valid_i,
    input  logic [4:0]       alu_rd_i,
    input  logic [31:0]      alu_data_i,
    output logic             alu_ready_o,

    output logic [4:0]       rsW_o,
    output logic [31:0]      dataW_o,
    output logic             regWEn_o,
    output logic [1:0]       grant_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_DBG  = 2'd3
    } src_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    src_e            sel;
    logic [4:0]      sel_rd;
    logic [31:0]     sel_data;
    logic [CNT_W-1:0] starve_cnt;
    logic            force_alu;

    assign force_alu = alu_valid_i & lsu_valid_i & (starve_cnt == LIMIT);

    // Readies are held low while reset is asserted so nothing transfers in the reset cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        sel      = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (!reset) begin
            if (dbg_valid_i) begin
                sel      = SRC_DBG;
                sel_rd   = dbg_rd_i;
                sel_data = dbg_data_i;
            end else if (force_alu) begin
                sel      = SRC_ALU;
                sel_rd   = alu_rd_i;
                sel_data = alu_data_i;
            end else if (lsu_valid_i) begin
                sel      = SRC_LSU;
                sel_rd   = lsu_rd_i;
                sel_data = lsu_data_i;
            end else if (alu_valid_i) begin
                sel      = SRC_ALU;
                sel_rd   = alu_rd_i;
                sel_data = alu_data_i;
            end
        end
    end

    assign dbg_ready_o = (sel == SRC_DBG);
    assign lsu_ready_o = (sel == SRC_LSU);
    assign alu_ready_o = (sel == SRC_ALU);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            regWEn_o   <= 1'b0;
            rsW_o      <= '0;
            dataW_o    <= '0;
            grant_o    <= SRC_NONE;
            starve_cnt <= '0;
        end else begin
            grant_o  <= sel;
            regWEn_o <= (sel != SRC_NONE) && (sel_rd != 5'd0);
            // Address and data hold when idle; only the enable marks a real write.
            if (sel != SRC_NONE) begin
                rsW_o   <= sel_rd;
                dataW_o <= sel_data;
            end
            if (!alu_valid_i || sel == SRC_ALU) begin
                starve_cnt <= '0;
            end else if (sel == SRC_LSU && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign starve_cnt_o = starve_cnt;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (rsW/dataW/regWEn) among three writeback requesters: debug, load/store unit (LSU) and ALU.
- Each requester uses a valid/ready handshake.
- At most one request is granted per cycle.
- The granted write is registered and presented to the register file on the next cycle.
- An ALU starvation counter guarantees forward progress while the LSU streams back-to-back loads.

Parameters:
STARVE_LIMIT, 4, consecutive ALU losses to LSU after which ALU is force-granted (legal range 1..15)
CNT_W, 4, width of the starvation counter (must satisfy 2^CNT_W > STARVE_LIMIT)

Ports:
clk_i  in  1  clock
reset  in  1  synchronous, active-high reset
dbg_valid_i  in  1  debug write request
dbg_rd_i  in  5  debug destination register
dbg_data_i  in  32  debug write data
dbg_ready_o  out  1  debug request accepted this cycle
lsu_valid_i  in  1  LSU writeback request
lsu_rd_i  in  5  LSU destination register
lsu_data_i  in  32  LSU write data
lsu_ready_o  out  1  LSU request accepted this cycle
alu_valid_i  in  1  ALU writeback request
alu_rd_i  in  5  ALU destination register
alu_data_i  in  32  ALU write data
alu_ready_o  out  1  ALU request accepted this cycle
rsW_o  out  5  register-file write address
dataW_o  out  32  register-file write data
regWEn_o  out  1  register-file write enable
grant_o  out  2  source of current output: 0 none, 1 ALU, 2 LSU, 3 debug
starve_cnt_o  out  CNT_W  current ALU starvation count (observability)

Behaviour:
- Everything is clocked on the rising edge of clk_i; reset is synchronous and active-high.
- Reset values: regWEn_o=0, rsW_o=0, dataW_o=0, grant_o=0, starve_cnt_o=0.
- The ready outputs are combinational from the valid inputs and the counter; their reset-cycle value is 0 (no grants while reset=1).
- Handshake:
  - Transfer occurs when valid & ready are both high in the same cycle.
  - A requester holds valid, rd and data stable until ready.
  - ready never depends on the requester's own rd or data.
- Grant selection (one per cycle, combinational from the valid inputs and the counter):
  1. dbg_valid_i set: debug granted.
  2. Else if alu_valid_i & lsu_valid_i & (starve_cnt == STARVE_LIMIT): ALU granted (forced).
  3. Else if lsu_valid_i: LSU granted.
  4. Else if alu_valid_i: ALU granted.
  5. Else no grant.
- Exactly one ready_o is high when any valid is high; all are low otherwise.
- Output stage (one-cycle latency): the granted rd/data/source are registered into rsW_o/dataW_o/grant_o.
  - regWEn_o <= granted & (rd != 0). Writes to x0 are accepted (ready=1) but produce regWEn_o=0; rsW_o and dataW_o still update; grant_o shows the source.
  - With no grant: regWEn_o=0, grant_o=0, rsW_o/dataW_o hold their previous values.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when the ALU is valid and LSU wins.
  - Clears to 0 when the ALU is granted or alu_valid_i is low.
  - Holds when debug wins.
- Same rd from multiple sources in one cycle: only the winner writes; losers stay pending. There is no merging or reordering within a source.
- Reset asserted mid-stream:
  - Output registers clear the next edge; no write is emitted for a request granted in the reset cycle.
  - The counter returns to 0.

Test Plan:
1. Reset: assert reset 2 cycles with all valids high -> all ready=0, regWEn_o=0, grant_o=0, starve_cnt_o=0.
2. Single ALU write rd=5 data=0xDEADBEEF -> alu_ready_o=1 same cycle; next cycle regWEn_o=1, rsW_o=5, dataW_o=0xDEADBEEF, grant_o=1.
3. LSU and ALU valid continuously (STARVE_LIMIT=4) -> grant sequence LSU,LSU,LSU,LSU,ALU,LSU...; starve_cnt_o counts 1,2,3,4,0.
4. Debug, LSU and ALU all valid -> debug granted first (grant_o=3); then LSU; counter holds across the debug cycle.
5. ALU write rd=0 data=0x1234 -> alu_ready_o=1; next cycle regWEn_o=0, grant_o=1.
6. Reset asserted the cycle an LSU grant is issued -> following cycle regWEn_o=0, grant_o=0; after reset deasserts, the held LSU request is granted normally.
